// File: rtl/vco_spi_master.sv
`timescale 1ns/1ps
// vco_spi_master
// Write-only SPI master feeding 32-bit register words from the settings bus to the
// front-end VCO/synthesizer. Words written to DATA_ADDR are queued in a 4-deep FIFO,
// shifted out MSB-first on vco_sclk/vco_sdata and latched with a vco_le pulse.
//
// Optional feature: define VCO_LOCK_MON_EN to synchronize vco_muxout and report
// locked / sticky lock_lost in the status word. Without it both bits read 0.
//
// Ports:
//   clock, reset_n         master clock, asynchronous active-low reset
//   serial_strobe/addr/data settings-bus write (single-cycle strobe)
//   vco_muxout             synthesizer lock detect (asynchronous)
//   vco_sclk/sdata/le      SPI clock (idles low), data, load enable
//   busy, done             word in flight / one-cycle end-of-word pulse
//   status                 {24'd0, lock_lost, locked, overflow, busy, 1'b0, fifo_level}
module vco_spi_master #(
    parameter logic [6:0] DATA_ADDR = 7'd40,
    parameter logic [6:0] CTRL_ADDR = 7'd41,
    parameter logic [7:0] CLKDIV    = 8'd4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        serial_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        vco_muxout,
    output logic        vco_sclk,
    output logic        vco_sdata,
    output logic        vco_le,
    output logic        busy,
    output logic        done,
    output logic [31:0] status
);

    typedef enum logic [2:0] {
        S_IDLE, S_SHIFT, S_LE_SETUP, S_LE_HIGH, S_GAP, S_DONE
    } state_t;

    // Counter reload values: one sclk half-period, and the LE high time.
    localparam logic [8:0] L_HALF = {1'b0, CLKDIV} - 9'd1;
    localparam logic [8:0] L_LE   = {CLKDIV, 1'b0} - 9'd1;

    state_t      r_state;
    logic [8:0]  r_cnt;
    logic [4:0]  r_bit;
    logic [31:0] r_shift;

    logic [31:0] r_mem [4];
    logic [1:0]  r_wr_ptr;
    logic [1:0]  r_rd_ptr;
    logic [2:0]  r_level;
    logic        r_overflow;

    logic w_push_req;
    logic w_ctrl;
    logic w_pop;
    logic w_push;
    logic w_ovf_set;
    logic w_locked;
    logic w_lock_lost;

    assign w_push_req = serial_strobe && (serial_addr == DATA_ADDR);
    assign w_ctrl     = serial_strobe && (serial_addr == CTRL_ADDR);
    assign w_pop      = (r_state == S_IDLE) && (r_level != 3'd0);
    // A pop in the same cycle frees a slot, so a push at full is still accepted.
    assign w_push     = w_push_req && ((r_level != 3'd4) || w_pop);
    assign w_ovf_set  = w_push_req && (r_level == 3'd4) && !w_pop;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= serial_data;
                r_wr_ptr        <= r_wr_ptr + 2'd1;
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + 2'd1;
            if (w_push && !w_pop)      r_level <= r_level + 3'd1;
            else if (!w_push && w_pop) r_level <= r_level - 3'd1;
        end
    end

    // Set has priority over clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                      r_overflow <= 1'b0;
        else if (w_ovf_set)                r_overflow <= 1'b1;
        else if (w_ctrl && serial_data[0]) r_overflow <= 1'b0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            vco_sclk  <= 1'b0;
            vco_sdata <= 1'b0;
            vco_le    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    done <= 1'b0;
                    busy <= 1'b0;
                    if (r_level != 3'd0) begin
                        r_shift   <= r_mem[r_rd_ptr];
                        vco_sdata <= r_mem[r_rd_ptr][31];
                        busy      <= 1'b1;
                        r_cnt     <= L_HALF;
                        r_bit     <= 5'd31;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (r_cnt != 9'd0) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else begin
                        r_cnt <= L_HALF;
                        if (!vco_sclk) begin
                            vco_sclk <= 1'b1;
                        end else begin
                            vco_sclk <= 1'b0;
                            if (r_bit == 5'd0) begin
                                r_state <= S_LE_SETUP;
                            end else begin
                                // Next bit goes out on the falling edge.
                                r_bit     <= r_bit - 5'd1;
                                r_shift   <= {r_shift[30:0], 1'b0};
                                vco_sdata <= r_shift[30];
                            end
                        end
                    end
                end
                S_LE_SETUP: begin
                    if (r_cnt != 9'd0) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else begin
                        r_cnt   <= L_LE;
                        vco_le  <= 1'b1;
                        r_state <= S_LE_HIGH;
                    end
                end
                S_LE_HIGH: begin
                    if (r_cnt != 9'd0) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else begin
                        r_cnt   <= L_HALF;
                        vco_le  <= 1'b0;
                        r_state <= S_GAP;
                    end
                end
                S_GAP: begin
                    if (r_cnt != 9'd0) begin
                        r_cnt <= r_cnt - 9'd1;
                    end else begin
                        done    <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef VCO_LOCK_MON_EN
    logic r_sync1;
    logic r_sync2;
    logic r_sync_prev;
    logic r_lock_lost;
    logic w_lock_fall;

    assign w_lock_fall = r_sync_prev && !r_sync2;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1     <= 1'b0;
            r_sync2     <= 1'b0;
            r_sync_prev <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_sync1     <= vco_muxout;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            if (w_lock_fall)                   r_lock_lost <= 1'b1;
            else if (w_ctrl && serial_data[1]) r_lock_lost <= 1'b0;
        end
    end

    assign w_locked    = r_sync2;
    assign w_lock_lost = r_lock_lost;
`else
    logic w_unused_muxout;
    assign w_unused_muxout = vco_muxout;
    assign w_locked        = 1'b0;
    assign w_lock_lost     = 1'b0;
`endif

    assign status = {24'd0, w_lock_lost, w_locked, r_overflow, busy, 1'b0, r_level};

endmodule

// File: tb/tb_vco_spi_master.sv
`timescale 1ns/1ps
// Scoreboard bench for vco_spi_master (CLKDIV=4). Stimulus pushes expected words;
// a monitor reassembles words from sclk rising edges and checks each LE pulse.
module tb_vco_spi_master;

    localparam logic [6:0] DATA_ADDR = 7'd40;
    localparam logic [6:0] CTRL_ADDR = 7'd41;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        serial_strobe = 1'b0;
    logic [6:0]  serial_addr = '0;
    logic [31:0] serial_data = '0;
    logic        vco_muxout = 1'b0;
    logic        vco_sclk;
    logic        vco_sdata;
    logic        vco_le;
    logic        busy;
    logic        done;
    logic [31:0] status;

    vco_spi_master #(
        .DATA_ADDR(DATA_ADDR),
        .CTRL_ADDR(CTRL_ADDR),
        .CLKDIV   (8'd4)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .serial_strobe(serial_strobe),
        .serial_addr  (serial_addr),
        .serial_data  (serial_data),
        .vco_muxout   (vco_muxout),
        .vco_sclk     (vco_sclk),
        .vco_sdata    (vco_sdata),
        .vco_le       (vco_le),
        .busy         (busy),
        .done         (done),
        .status       (status)
    );

    always #5 clock = ~clock;

    int          n_checks = 0;
    int          n_err = 0;
    int          le_pulses = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the next one.
    task automatic write_reg(input logic [6:0] a, input logic [31:0] d);
        serial_strobe = 1'b1;
        serial_addr   = a;
        serial_data   = d;
        @(posedge clock);
        #1;
        serial_strobe = 1'b0;
        serial_addr   = '0;
        serial_data   = '0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clock);
            if (!busy && status[2:0] == 3'd0 && exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, {31'd0, ok}, 32'd1);
        @(posedge clock);
        #1;
    endtask

    // Monitor state
    int          m_cyc = 0;
    int          m_last_fall = 0;
    int          m_le_start = 0;
    int          m_busy_rise = 0;
    int          m_nbits = 0;
    logic        m_p_sclk = 1'b0;
    logic        m_p_le = 1'b0;
    logic        m_p_busy = 1'b0;
    logic [31:0] m_acc = '0;
    logic [31:0] m_exp = '0;

    initial begin : monitor
        forever begin
            @(negedge clock);
            m_cyc++;
            if (!reset_n) begin
                m_nbits  = 0;
                m_acc    = '0;
                m_p_sclk = 1'b0;
                m_p_le   = 1'b0;
                m_p_busy = 1'b0;
            end else begin
                if (vco_sclk && !m_p_sclk) begin
                    m_acc = {m_acc[30:0], vco_sdata};
                    m_nbits++;
                end
                if (!vco_sclk && m_p_sclk) m_last_fall = m_cyc;
                if (busy && !m_p_busy) m_busy_rise = m_cyc;
                if (vco_le && !m_p_le) begin
                    le_pulses++;
                    m_le_start = m_cyc;
                    check("le_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                    check("le_setup", m_cyc - m_last_fall, 32'd4);
                end
                if (!vco_le && m_p_le) begin
                    check("le_width", m_cyc - m_le_start, 32'd8);
                    check("bit_count", m_nbits, 32'd32);
                    if (exp_q.size() != 0) begin
                        m_exp = exp_q.pop_front();
                        check("word", m_acc, m_exp);
                    end
                    m_nbits = 0;
                end
                if (done) check("done_latency", m_cyc - m_busy_rise, 32'd272);
                m_p_sclk = vco_sclk;
                m_p_le   = vco_le;
                m_p_busy = busy;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [31:0] words[6];
        bit          found;
        int          p;

        // Reset state
        tick(3);
        check("rst_status", status, 32'd0);
        check("rst_sclk", {31'd0, vco_sclk}, 32'd0);
        check("rst_sdata", {31'd0, vco_sdata}, 32'd0);
        check("rst_le", {31'd0, vco_le}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Other addresses are ignored
        write_reg(7'd42, 32'hFFFF_FFFF);
        tick(1);
        check("ignored_addr", status, 32'd0);

        // Single word and first-word latency
        exp_q.push_back(32'hA5C3_0F01);
        write_reg(DATA_ADDR, 32'hA5C3_0F01);
        check("lvl_n1", {29'd0, status[2:0]}, 32'd1);
        tick(1);
        check("busy_n2", {31'd0, busy}, 32'd1);
        check("sdata_n2", {31'd0, vco_sdata}, 32'd1);
        check("lvl_n2", {29'd0, status[2:0]}, 32'd0);
        tick(3);
        check("sclk_low_n5", {31'd0, vco_sclk}, 32'd0);
        tick(1);
        check("sclk_rise_n6", {31'd0, vco_sclk}, 32'd1);
        wait_idle("idle_single", 400);

        // Queue and overflow: sixth word dropped
        words = '{32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF,
                  32'h1234_5678, 32'hDEAD_BEEF, 32'hCAFE_F00D};
        for (int i = 0; i < 5; i++) exp_q.push_back(words[i]);
        p = le_pulses;
        for (int i = 0; i < 6; i++) write_reg(DATA_ADDR, words[i]);
        check("ovf_level", {29'd0, status[2:0]}, 32'd4);
        check("ovf_set", {31'd0, status[5]}, 32'd1);
        wait_idle("idle_queue", 2000);
        check("ovf_pulses", le_pulses - p, 32'd5);
        check("ovf_sticky", {31'd0, status[5]}, 32'd1);
        write_reg(CTRL_ADDR, 32'd1);
        check("ovf_clear", {31'd0, status[5]}, 32'd0);

        // Push in the exact cycle the FSM pops at level 4
        words = '{32'h0F0F_0F0F, 32'hF0F0_F0F0, 32'h5555_AAAA,
                  32'h0123_4567, 32'h89AB_CDEF, 32'h7654_3210};
        for (int i = 0; i < 6; i++) exp_q.push_back(words[i]);
        for (int i = 0; i < 5; i++) write_reg(DATA_ADDR, words[i]);
        check("pp_fill", {29'd0, status[2:0]}, 32'd4);
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        check("pp_done_seen", {31'd0, found}, 32'd1);
        @(posedge clock);
        #1;
        check("pp_idle_cycle", {31'd0, busy}, 32'd0);
        write_reg(DATA_ADDR, words[5]);
        check("pp_level", {29'd0, status[2:0]}, 32'd4);
        check("pp_no_ovf", {31'd0, status[5]}, 32'd0);
        check("pp_busy", {31'd0, busy}, 32'd1);
        wait_idle("idle_pushpop", 2500);

        // Reset during bit 15: word must never be latched
        p = le_pulses;
        write_reg(DATA_ADDR, 32'h3C3C_C3C3);
        tick(1);
        check("mid_busy", {31'd0, busy}, 32'd1);
        tick(130);
        reset_n = 1'b0;
        #1;
        check("mid_sclk", {31'd0, vco_sclk}, 32'd0);
        check("mid_sdata", {31'd0, vco_sdata}, 32'd0);
        check("mid_le", {31'd0, vco_le}, 32'd0);
        check("mid_busy0", {31'd0, busy}, 32'd0);
        check("mid_status", status, 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(400);
        check("mid_no_le", le_pulses - p, 32'd0);
        check("mid_fifo_empty", {29'd0, status[2:0]}, 32'd0);
        check("mid_idle", {31'd0, busy}, 32'd0);

        // Lock monitor
`ifdef VCO_LOCK_MON_EN
        vco_muxout = 1'b1;
        tick(3);
        check("locked", {31'd0, status[6]}, 32'd1);
        check("lock_lost_0", {31'd0, status[7]}, 32'd0);
        vco_muxout = 1'b0;
        tick(5);
        check("unlocked", {31'd0, status[6]}, 32'd0);
        check("lock_lost_1", {31'd0, status[7]}, 32'd1);
        write_reg(CTRL_ADDR, 32'd2);
        check("lock_lost_clr", {31'd0, status[7]}, 32'd0);
`else
        vco_muxout = 1'b1;
        tick(3);
        check("lock_bits_hi", {30'd0, status[7:6]}, 32'd0);
        vco_muxout = 1'b0;
        tick(5);
        check("lock_bits_lo", {30'd0, status[7:6]}, 32'd0);
        write_reg(CTRL_ADDR, 32'd2);
        check("lock_bits_clr", {30'd0, status[7:6]}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
